// File: rtl/si5340_pkg.sv
// si5340_pkg -- shared types and constants for the Si5340 register arbiter.
//
// Contents:
//   state_e          arbiter FSM states
//   req_t            latched request (we, {page, register} address, write data)
//   PAGE_REG_DEFAULT Si5340 page-select register address
package si5340_pkg;

    localparam logic [7:0] PAGE_REG_DEFAULT = 8'h01;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PAGE_CMD  = 3'd1,
        PAGE_WAIT = 3'd2,
        DATA_CMD  = 3'd3,
        DATA_WAIT = 3'd4,
        RESP      = 3'd5
    } state_e;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;   // {page, register}
        logic [7:0]  wdata;
    } req_t;

endpackage

// File: rtl/si5340_rr_grant.sv
// si5340_rr_grant -- two-requester round-robin grant with a registered
// last-grant pointer.
//
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   req_i[1:0]    requests
//   en_i          the grant is taken this cycle; updates the pointer
//   gnt_o[1:0]    one-hot grant (combinational), zero when no request
//
// After reset the pointer reads "port 1 last", so port 0 wins the first tie.
module si5340_rr_grant (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic last_q;  // 1 = port 1 was granted last

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (en_i && (|req_i)) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/si5340_reg_arbiter.sv
// si5340_reg_arbiter -- arbitrates two register requesters (port 0 config
// loader, port 1 runtime host) onto one byte-level I2C master, inserting a
// Si5340 page-select write ahead of each register access.
//
// Optional feature: define SI5340_PAGE_CACHE_EN to remember the last page
// written and skip the page write when the next access targets the same page.
// Without it a page write precedes every transaction.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o[1:0] per-requester request / one-cycle accept
//   req_we_i, req_addr_i, req_wdata_i  request payload ({page, reg} address)
//   rsp_valid_o[1:0], rsp_rdata_o, rsp_err_o  one-cycle response to the owner
//   m_cmd_*                      command to the I2C master
//   m_rsp_*                      master response (err = NACK / arb lost)
//   dbg_state_o                  current FSM state
//
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both 1. The command side holds valid and payload stable until ready; the
// requester side sees req_ready_o as a one-cycle accept strobe, and the
// response sides (m_rsp_valid_i, rsp_valid_o) are single-cycle pulses with no
// back-pressure.
module si5340_reg_arbiter
    import si5340_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] PAGE_REG       = PAGE_REG_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [1:0]      req_valid_i,
    output logic [1:0]      req_ready_o,
    input  logic [1:0]      req_we_i,
    input  logic [1:0][15:0] req_addr_i,
    input  logic [1:0][7:0] req_wdata_i,
    output logic [1:0]      rsp_valid_o,
    output logic [7:0]      rsp_rdata_o,
    output logic            rsp_err_o,
    output logic            m_cmd_valid_o,
    input  logic            m_cmd_ready_i,
    output logic            m_cmd_we_o,
    output logic [7:0]      m_cmd_reg_o,
    output logic [7:0]      m_cmd_wdata_o,
    input  logic            m_rsp_valid_i,
    input  logic [7:0]      m_rsp_rdata_i,
    input  logic            m_rsp_err_i,
    output state_e          dbg_state_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    req_t             req_q, sel_req;
    logic             owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       rdata_q;
    logic             err_q;
    logic [1:0]       gnt;
    logic             gnt_idx;
    logic             accept;
    logic             need_page;
    logic             in_wait;
    logic             timeout;
    logic             wait_done;
    logic             fail_evt;

    si5340_rr_grant u_rr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req_valid_i),
        .en_i  (accept),
        .gnt_o (gnt)
    );

    assign gnt_idx = gnt[1];
    assign accept  = (state_q == IDLE) && (|req_valid_i) && !rst_i;
    assign sel_req = {req_we_i[gnt_idx], req_addr_i[gnt_idx], req_wdata_i[gnt_idx]};

    assign in_wait   = (state_q == PAGE_WAIT) || (state_q == DATA_WAIT);
    assign timeout   = (cnt_q == CNT_LAST);
    // A response in the same cycle as the timeout still counts as a response.
    assign wait_done = in_wait && (m_rsp_valid_i || timeout);
    assign fail_evt  = in_wait && (m_rsp_valid_i ? m_rsp_err_i : timeout);

`ifdef SI5340_PAGE_CACHE_EN
    logic       cache_vld_q;
    logic [7:0] cache_page_q;

    assign need_page = !(cache_vld_q && (cache_page_q == sel_req.addr[15:8]));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cache_vld_q  <= 1'b0;
            cache_page_q <= 8'h00;
        end else if ((state_q == PAGE_WAIT) && m_rsp_valid_i && !m_rsp_err_i) begin
            cache_vld_q  <= 1'b1;
            cache_page_q <= req_q.addr[15:8];
        end else if (fail_evt) begin
            // After any failure the device page is unknown.
            cache_vld_q  <= 1'b0;
        end
    end
`else
    assign need_page = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = need_page ? PAGE_CMD : DATA_CMD;
            PAGE_CMD:  if (m_cmd_ready_i) state_d = PAGE_WAIT;
            PAGE_WAIT: if (wait_done) state_d = fail_evt ? RESP : DATA_CMD;
            DATA_CMD:  if (m_cmd_ready_i) state_d = DATA_WAIT;
            DATA_WAIT: if (wait_done) state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o   = accept ? gnt : 2'b00;
        m_cmd_valid_o = 1'b0;
        m_cmd_we_o    = 1'b0;
        m_cmd_reg_o   = 8'h00;
        m_cmd_wdata_o = 8'h00;
        rsp_valid_o   = 2'b00;
        rsp_rdata_o   = 8'h00;
        rsp_err_o     = 1'b0;
        case (state_q)
            PAGE_CMD: begin
                m_cmd_valid_o = 1'b1;
                m_cmd_we_o    = 1'b1;
                m_cmd_reg_o   = PAGE_REG;
                m_cmd_wdata_o = req_q.addr[15:8];
            end
            DATA_CMD: begin
                m_cmd_valid_o = 1'b1;
                m_cmd_we_o    = req_q.we;
                m_cmd_reg_o   = req_q.addr[7:0];
                m_cmd_wdata_o = req_q.wdata;
            end
            RESP: begin
                rsp_valid_o = owner_q ? 2'b10 : 2'b01;
                rsp_rdata_o = rdata_q;
                rsp_err_o   = err_q;
            end
            default: ;
        endcase
    end

    assign dbg_state_o = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q   <= sel_req;
                owner_q <= gnt_idx;
            end
            if (in_wait && (state_d == state_q)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
            if (wait_done) begin
                err_q   <= fail_evt;
                // Read data is returned only for a successful data-phase read.
                rdata_q <= ((state_q == DATA_WAIT) && !fail_evt && !req_q.we) ?
                           m_rsp_rdata_i : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_si5340_reg_arbiter.sv
// tb_si5340_reg_arbiter -- directed bench for si5340_reg_arbiter.
// Expected grants, master commands and responses are pushed into queues when
// a transaction is scheduled; a negedge monitor pops and compares them when
// the DUT presents req_ready, a command handshake or rsp_valid.
module tb_si5340_reg_arbiter;
    import si5340_pkg::*;

    localparam int TO = 20;
`ifdef SI5340_PAGE_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [1:0]       req_we = '0;
    logic [1:0][15:0] req_addr = '0;
    logic [1:0][7:0]  req_wdata = '0;
    logic [1:0]       rsp_valid;
    logic [7:0]       rsp_rdata;
    logic             rsp_err;
    logic             m_cmd_valid;
    logic             m_cmd_ready = 1'b1;
    logic             m_cmd_we;
    logic [7:0]       m_cmd_reg;
    logic [7:0]       m_cmd_wdata;
    logic             m_rsp_valid = 1'b0;
    logic [7:0]       m_rsp_rdata = 8'h00;
    logic             m_rsp_err = 1'b0;
    state_e           dbg_state;

    si5340_reg_arbiter #(.TIMEOUT_CYCLES(TO), .PAGE_REG(8'h01)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .m_cmd_valid_o(m_cmd_valid), .m_cmd_ready_i(m_cmd_ready),
        .m_cmd_we_o(m_cmd_we), .m_cmd_reg_o(m_cmd_reg), .m_cmd_wdata_o(m_cmd_wdata),
        .m_rsp_valid_i(m_rsp_valid), .m_rsp_rdata_i(m_rsp_rdata), .m_rsp_err_i(m_rsp_err),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [1:0]  grant_q[$];
    logic [16:0] cmd_q[$];   // {we, reg, wdata}
    logic [17:0] rsp_q[$];   // {port, rdata, err, latency from last cmd handshake}
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_hs  = 0;
    bit   mc_valid = 1'b0;   // page-cache model
    logic [7:0] mc_page = 8'h00;

    // ---------------- master model controls ----------------
    bit         mute_all  = 1'b0;
    bit         mute_data = 1'b0;
    bit         nack_page = 1'b0;
    logic [7:0] rdata_val = 8'h00;
    bit         pend = 1'b0;
    bit         pend_err = 1'b0;
    logic [7:0] pend_rdata = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Master: accepts commands, answers one cycle after the handshake.
    always @(negedge clk) begin
        if (m_cmd_valid && m_cmd_ready && !mute_all) begin
            if (m_cmd_we && m_cmd_reg == 8'h01) begin
                pend = 1'b1; pend_err = nack_page; pend_rdata = 8'hEE;
            end else if (!mute_data) begin
                pend = 1'b1; pend_err = 1'b0; pend_rdata = rdata_val;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        m_rsp_valid = pend;
        m_rsp_err   = pend ? pend_err : 1'b0;
        m_rsp_rdata = pend ? pend_rdata : 8'h00;
        pend = 1'b0;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [17:0] r;
        logic [16:0] c;
        cyc++;
        if (!rst) begin
            if (req_ready != 2'b00) begin
                if (grant_q.size() == 0) check("grant_unexpected", 32'(req_ready), 32'd0);
                else check("grant", 32'(req_ready), 32'(grant_q.pop_front()));
            end
            if (m_cmd_valid && m_cmd_ready) begin
                last_hs = cyc;
                if (cmd_q.size() == 0) check("cmd_unexpected", 32'(m_cmd_valid), 32'd0);
                else begin
                    c = cmd_q.pop_front();
                    check("cmd", 32'({m_cmd_we, m_cmd_reg, m_cmd_wdata}), 32'(c));
                end
            end
            if (rsp_valid != 2'b00) begin
                if (rsp_q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                else begin
                    r = rsp_q.pop_front();
                    check("rsp_port",    32'(rsp_valid), r[17] ? 32'd2 : 32'd1);
                    check("rsp_rdata",   32'(rsp_rdata), 32'(r[16:9]));
                    check("rsp_err",     32'(rsp_err),   32'(r[8]));
                    check("rsp_latency", 32'(cyc - last_hs), 32'(r[7:0]));
                end
            end
        end
    end

    // ---------------- expectation builder (with page-cache model) ----------------
    task automatic expect_txn(input int p, input logic we, input logic [15:0] addr,
                              input logic [7:0] wdata, input logic [7:0] rdata,
                              input bit page_nack, input bit data_to);
        logic pb = (p == 1);
        grant_q.push_back(pb ? 2'b10 : 2'b01);
        if (!(CACHE_EN && mc_valid && mc_page == addr[15:8])) begin
            cmd_q.push_back({1'b1, 8'h01, addr[15:8]});
            if (page_nack) begin
                mc_valid = 1'b0;
                rsp_q.push_back({pb, 8'h00, 1'b1, 8'd2});
                return;
            end
            mc_valid = 1'b1;
            mc_page  = addr[15:8];
        end
        cmd_q.push_back({we, addr[7:0], wdata});
        if (data_to) begin
            mc_valid = 1'b0;
            rsp_q.push_back({pb, 8'h00, 1'b1, 8'(TO + 1)});
        end else begin
            rsp_q.push_back({pb, we ? 8'h00 : rdata, 1'b0, 8'd2});
        end
    endtask

    // ---------------- drivers ----------------
    task automatic issue(input int p, input logic we, input logic [15:0] addr, input logic [7:0] wdata);
        bit got = 1'b0;
        @(posedge clk); #1;
        req_valid[p] = 1'b1; req_we[p] = we; req_addr[p] = addr; req_wdata[p] = wdata;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (req_ready[p]) got = 1'b1;
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL grant_wait port %0d: req_ready never seen, expected within 100 cycles", p);
        end
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((grant_q.size() + cmd_q.size() + rsp_q.size()) != 0 && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL drain: %0d items still queued, expected 0",
                     grant_q.size() + cmd_q.size() + rsp_q.size());
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({req_ready, rsp_valid, rsp_rdata, rsp_err,
                    m_cmd_valid, m_cmd_we, m_cmd_reg, m_cmd_wdata});
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_outputs(), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk); #1; rst = 1'b0;

        // Single write, cold cache: page write then data write.
        expect_txn(0, 1'b1, 16'h0B24, 8'hC3, 8'h00, 0, 0);
        issue(0, 1'b1, 16'h0B24, 8'hC3);
        wait_idle();

        // Back-to-back write on the same page.
        expect_txn(0, 1'b1, 16'h0B25, 8'h7E, 8'h00, 0, 0);
        issue(0, 1'b1, 16'h0B25, 8'h7E);
        wait_idle();

        // Port 1 read on a new page.
        rdata_val = 8'h5A;
        expect_txn(1, 1'b0, 16'h0A00, 8'h00, 8'h5A, 0, 0);
        issue(1, 1'b0, 16'h0A00, 8'h00);
        wait_idle();

        // Tie with port 1 granted last: port 0 first.
        expect_txn(0, 1'b1, 16'h0A10, 8'h11, 8'h00, 0, 0);
        expect_txn(1, 1'b1, 16'h0A11, 8'h22, 8'h00, 0, 0);
        fork
            issue(0, 1'b1, 16'h0A10, 8'h11);
            issue(1, 1'b1, 16'h0A11, 8'h22);
        join
        wait_idle();

        // Port 0 read leaves port 0 as last grant.
        rdata_val = 8'hA5;
        expect_txn(0, 1'b0, 16'h0A05, 8'h00, 8'hA5, 0, 0);
        issue(0, 1'b0, 16'h0A05, 8'h00);
        wait_idle();

        // Tie with port 0 granted last: port 1 first; write returns 00 rdata.
        rdata_val = 8'h96;
        expect_txn(1, 1'b1, 16'h0A21, 8'h33, 8'h00, 0, 0);
        expect_txn(0, 1'b0, 16'h0A20, 8'h00, 8'h96, 0, 0);
        fork
            issue(0, 1'b0, 16'h0A20, 8'h00);
            issue(1, 1'b1, 16'h0A21, 8'h33);
        join
        wait_idle();

        // Page write NACKed: error response, cache dropped.
        nack_page = 1'b1;
        expect_txn(0, 1'b1, 16'h0C00, 8'h44, 8'h00, 1, 0);
        issue(0, 1'b1, 16'h0C00, 8'h44);
        wait_idle();
        nack_page = 1'b0;
        expect_txn(0, 1'b1, 16'h0A30, 8'h55, 8'h00, 0, 0);
        issue(0, 1'b1, 16'h0A30, 8'h55);
        wait_idle();

        // Master silent in the data phase: timeout, then page write reissued.
        mute_data = 1'b1;
        expect_txn(1, 1'b0, 16'h0D07, 8'h00, 8'h00, 0, 1);
        issue(1, 1'b0, 16'h0D07, 8'h00);
        wait_idle();
        mute_data = 1'b0;
        rdata_val = 8'h3C;
        expect_txn(1, 1'b0, 16'h0D08, 8'h00, 8'h3C, 0, 0);
        issue(1, 1'b0, 16'h0D08, 8'h00);
        wait_idle();

        // Command back-pressure for a few cycles.
        @(posedge clk); #1; m_cmd_ready = 1'b0;
        expect_txn(0, 1'b1, 16'h0D09, 8'h66, 8'h00, 0, 0);
        issue(0, 1'b1, 16'h0D09, 8'h66);
        repeat (3) @(posedge clk);
        #1; m_cmd_ready = 1'b1;
        wait_idle();

        // Reset while waiting on the page write.
        mute_all = 1'b1;
        grant_q.push_back(2'b01);
        cmd_q.push_back({1'b1, 8'h01, 8'h0E});
        issue(0, 1'b1, 16'h0E00, 8'h70);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (dbg_state == PAGE_WAIT) found = 1'b1;
        end
        check("reach_page_wait", 32'(found), 32'd1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs", all_outputs(), 32'd0);
        check("mid_reset_state", 32'(dbg_state), 32'(IDLE));
        cmd_q.delete(); rsp_q.delete();
        mc_valid = 1'b0;
        mute_all = 1'b0;
        repeat (5) @(negedge clk);

        // After reset: pointer back to "port 1 last", cache cold.
        rdata_val = 8'hC8;
        expect_txn(0, 1'b1, 16'h0E01, 8'h77, 8'h00, 0, 0);
        expect_txn(1, 1'b0, 16'h0E02, 8'h00, 8'hC8, 0, 0);
        fork
            issue(0, 1'b1, 16'h0E01, 8'h77);
            issue(1, 1'b0, 16'h0E02, 8'h00);
        join
        wait_idle();

        repeat (3) @(negedge clk);
        check("queues_drained", 32'(grant_q.size() + cmd_q.size() + rsp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
